// File: rtl/shift_add_multiplier_pkg.sv
// Shared FSM state encoding and sizing helper for the shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_add_multiplier_pkg;

  // Binary 2-bit state encoding; the value 2'd3 is never entered.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the bit counter at elaboration time.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand request (start/in_ready) and product return (p_valid/p_ack) bundle.
// Latency: n/a (wiring only).
// Backpressure: producer waits on in_ready, multiplier holds product until p_ack.
interface shift_add_multiplier_if #(
  parameter int A_W = 4,
  parameter int B_W = 3
);
  localparam int P_W = A_W + B_W;

  logic           start;
  logic [A_W-1:0] a_in;
  logic [B_W-1:0] b_in;
  logic           in_ready;
  logic           p_valid;
  logic           p_ack;
  logic [P_W-1:0] product;

  // Operand producer / product consumer side.
  modport master (
    output start, a_in, b_in, p_ack,
    input  in_ready, p_valid, product
  );

  // Multiplier side.
  modport slave (
    input  start, a_in, b_in, p_ack,
    output in_ready, p_valid, product
  );
endinterface

// File: rtl/shift_add_multiplier_datapath.sv
// Multiplicand/multiplier shift registers and accumulator for shift-add multiply.
// Latency: one multiplier bit consumed per step pulse.
// Backpressure: none; advances only when the controller asserts step.
module shift_add_datapath #(
  parameter int A_W = 4,
  parameter int B_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [A_W-1:0]       a_val,
  input  logic [B_W-1:0]       b_val,
  output logic [A_W+B_W-1:0]   acc_next,
  output logic                 mult_next_zero
);
  localparam int P_W = A_W + B_W;

  logic [P_W-1:0] mcand;
  logic [B_W-1:0] mult;
  logic [P_W-1:0] acc;

  // P_W bits always hold the full product, so the add never carries out.
  assign acc_next       = mult[0] ? (acc + mcand) : acc;
  assign mult_next_zero = ((mult >> 1) == '0);

  // Load operands on acceptance, then shift one multiplier bit per step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mult  <= '0;
      acc   <= '0;
    end else if (load) begin
      mcand <= P_W'(a_val);
      mult  <= b_val;
      acc   <= '0;
    end else if (step) begin
      acc   <= acc_next;
      mcand <= mcand << 1;
      mult  <= mult >> 1;
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier, constant or run-time multiplier.
// Latency: B_W+1 edges from acceptance (early exit: 1 + bit length of multiplier, min 2).
// Backpressure: product held in DONE until p_ack; start ignored outside IDLE.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int A_W        = 4,
  parameter int B_W        = 3,
  parameter int USE_CONST  = 1,
  parameter int CONST_B    = 5,
  parameter int EARLY_EXIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);
  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = clog2(B_W) + 1;

  if (CONST_B < 0 || CONST_B >= (1 << B_W)) begin : g_const_range
    $error("CONST_B does not fit in B_W bits");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [P_W-1:0]     product_q;
  logic               load, step, last_step;
  logic [B_W-1:0]     b_sel;
  logic [P_W-1:0]     acc_next;
  logic               mult_next_zero;

  assign b_sel     = (USE_CONST != 0) ? B_W'(CONST_B) : bus.b_in;
  assign last_step = (count_q == CNT_W'(B_W - 1)) ||
                     ((EARLY_EXIT != 0) && mult_next_zero);

  shift_add_datapath #(
    .A_W (A_W),
    .B_W (B_W)
  ) u_datapath (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .step           (step),
    .a_val          (bus.a_in),
    .b_val          (b_sel),
    .acc_next       (acc_next),
    .mult_next_zero (mult_next_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath controls; start and p_ack only matter in their own states.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_step) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.p_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit counter and product capture on the final RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      product_q <= '0;
    end else begin
      if (load)      count_q <= '0;
      else if (step) count_q <= count_q + 1'b1;
      if (step && last_step) product_q <= acc_next;
    end
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.p_valid  = (state_q == ST_DONE);
  assign bus.product  = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: constant x5 instance and run-time-operand early-exit instance.
// Latency: checked against a bit-length model of the multiplier.
// Backpressure: exercised by withholding p_ack while pulsing start.
module tb_shift_add_multiplier;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  shift_add_multiplier_if #(.A_W(4), .B_W(3)) ifc_c ();
  shift_add_multiplier_if #(.A_W(4), .B_W(3)) ifc_v ();

  shift_add_multiplier #(
    .A_W(4), .B_W(3), .USE_CONST(1), .CONST_B(5), .EARLY_EXIT(0)
  ) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (ifc_c)
  );

  shift_add_multiplier #(
    .A_W(4), .B_W(3), .USE_CONST(0), .CONST_B(5), .EARLY_EXIT(1)
  ) dut_v (
    .clk (clk),
    .rst (rst),
    .bus (ifc_v)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic drive(input int sel, input logic st, input int a, input int b, input logic ack);
    if (sel == 0) begin
      ifc_c.start = st; ifc_c.a_in = 4'(a); ifc_c.b_in = 3'(b); ifc_c.p_ack = ack;
    end else begin
      ifc_v.start = st; ifc_v.a_in = 4'(a); ifc_v.b_in = 3'(b); ifc_v.p_ack = ack;
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? ifc_c.in_ready : ifc_v.in_ready;
  endfunction

  function automatic logic get_vld(input int sel);
    return (sel == 0) ? ifc_c.p_valid : ifc_v.p_valid;
  endfunction

  function automatic logic [31:0] get_prod(input int sel);
    return (sel == 0) ? 32'(ifc_c.product) : 32'(ifc_v.product);
  endfunction

  // Reference: edges from acceptance (inclusive) until p_valid is seen.
  function automatic int model_lat(input int sel, input int b);
    int n;
    int v;
    if (sel == 0) return 3 + 1;
    n = 0;
    v = b;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return 1 + ((n == 0) ? 1 : n);
  endfunction

  task automatic wait_ready(input int sel, input string tag);
    int k;
    k = 0;
    while (!get_rdy(sel) && k < 30) begin
      tick();
      k++;
    end
    chk({tag, "_ready_wait"}, 32'(get_rdy(sel)), 32'd1);
  endtask

  // One full transaction with p_ack held high throughout.
  task automatic do_op(input int sel, input int a, input int b, input string tag);
    int lat;
    int bm;
    bm = (sel == 0) ? 5 : b;
    wait_ready(sel, tag);
    drive(sel, 1'b1, a, b, 1'b1);
    tick();
    drive(sel, 1'b0, $urandom_range(0, 15), $urandom_range(0, 7), 1'b1);
    lat = 1;
    while (!get_vld(sel) && lat < 40) begin
      chk({tag, "_busy_in_ready"}, 32'(get_rdy(sel)), 32'd0);
      tick();
      lat++;
    end
    chk({tag, "_p_valid"}, 32'(get_vld(sel)), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(model_lat(sel, b)));
    chk({tag, "_product"}, get_prod(sel), 32'(a * bm));
    tick();
    chk({tag, "_valid_drop"}, 32'(get_vld(sel)), 32'd0);
    chk({tag, "_ready_back"}, 32'(get_rdy(sel)), 32'd1);
    chk({tag, "_product_hold"}, get_prod(sel), 32'(a * bm));
    drive(sel, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int ops[3];
    int idx;
    int rcount;
    int k;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("reset_in_ready", 32'(get_rdy(s)), 32'd1);
      chk("reset_p_valid", 32'(get_vld(s)), 32'd0);
      chk("reset_product", get_prod(s), 32'd0);
    end
    tick();
    rst = 1'b0;
    tick();

    // Constant x5: a=9 first, then the full operand sweep.
    do_op(0, 9, 0, "c_a9");
    for (int a = 0; a < 16; a++) do_op(0, a, 0, "c_sweep");

    // Run-time multiplier with early exit.
    do_op(1, 15, 7, "v_15x7");
    do_op(1, 6, 0, "v_6x0");
    do_op(1, 1, 4, "v_1x4");
    do_op(1, 11, 1, "v_11x1");

    // Backpressure: product held while start is pulsed with new operands.
    wait_ready(0, "bp");
    drive(0, 1'b1, 6, 0, 1'b0);
    tick();
    drive(0, 1'b0, 6, 0, 1'b0);
    k = 0;
    while (!get_vld(0) && k < 20) begin
      tick();
      k++;
    end
    chk("bp_valid", 32'(get_vld(0)), 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive(0, (i % 2) == 0, 13, 0, 1'b0);
      tick();
      chk("bp_hold_valid", 32'(get_vld(0)), 32'd1);
      chk("bp_hold_product", get_prod(0), 32'd30);
      chk("bp_hold_ready", 32'(get_rdy(0)), 32'd0);
    end
    drive(0, 1'b1, 13, 0, 1'b1);
    tick();
    chk("bp_ack_ready", 32'(get_rdy(0)), 32'd1);
    chk("bp_ack_valid", 32'(get_vld(0)), 32'd0);
    chk("bp_ack_product", get_prod(0), 32'd30);
    drive(0, 1'b0, 13, 0, 1'b0);
    tick();
    chk("bp_start_not_queued", 32'(get_rdy(0)), 32'd1);

    // Reset during the second RUN cycle aborts the operation.
    drive(0, 1'b1, 9, 0, 1'b0);
    tick();
    drive(0, 1'b0, 9, 0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(get_rdy(0)), 32'd1);
    chk("arst_p_valid", 32'(get_vld(0)), 32'd0);
    chk("arst_product", get_prod(0), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_no_valid", 32'(get_vld(0)), 32'd0);
    end
    do_op(0, 3, 0, "c_after_rst");

    // Back-to-back with start and p_ack held high; garbage operands while busy.
    ops[0] = 2; ops[1] = 7; ops[2] = 11;
    idx = 0;
    rcount = 0;
    for (int cyc = 0; cyc < 60 && rcount < 3; cyc++) begin
      if (get_vld(0)) begin
        chk("b2b_product", get_prod(0), 32'(5 * ops[rcount]));
        rcount++;
      end
      if (get_rdy(0) && idx < 3) begin
        drive(0, 1'b1, ops[idx], 0, 1'b1);
        idx++;
      end else begin
        drive(0, idx < 3, $urandom_range(0, 15), 0, 1'b1);
      end
      if (idx == 3 && !get_rdy(0)) drive(0, 1'b0, 0, 0, 1'b1);
      tick();
    end
    chk("b2b_count", 32'(rcount), 32'd3);
    drive(0, 1'b0, 0, 0, 1'b0);
    tick();
    tick();

    // Randomized operands on both instances.
    for (int i = 0; i < 24; i++) begin
      do_op(i % 2, $urandom_range(0, 15), $urandom_range(0, 7), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
